// File: rtl/imm_field_encoder.sv
// Packs an immediate plus register/function fields into RISC-V instruction bits [31:7].
// Optional feature macro: IMM_ENC_SPLIT_EN (wide I-type immediates become a U beat plus an I beat).

`ifndef RTYPE
`define RTYPE  3'd0
`define ITYPE  3'd1
`define STYPE  3'd2
`define BTYPE  3'd3
`define UTYPE  3'd4
`define JTYPE  3'd5
`define NOTYPE 3'd7
`endif

// state | meaning
// IDLE  | output register empty, or holding a single-beat / final beat
// SPLIT | beat 1 of a split is held; beat 2 fields are latched
module imm_field_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_bits,
    output logic [2:0]  out_type,
    output logic        out_last,
    output logic        out_err,
    output logic [15:0] err_count
);

`ifdef IMM_ENC_SPLIT_EN
    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

    state_t      state, state_nxt;
    logic        accept, consume;
    logic        i_ok, s_ok, b_ok, j_ok, u_ok;
    logic [24:0] enc_bits;
    logic        enc_err;
    logic        valid_nxt, last_nxt, err_nxt;
    logic [24:0] bits_nxt;
    logic [2:0]  type_nxt;

`ifdef IMM_ENC_SPLIT_EN
    logic        enc_split;
    logic [19:0] hi20;
    logic [24:0] beat2_bits, beat2_nxt;
`endif

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    assign i_ok = (in_imm[31:11] == {21{in_imm[31]}});
    assign s_ok = i_ok;
    assign b_ok = !in_imm[0] && (in_imm[31:12] == {20{in_imm[31]}});
    assign j_ok = !in_imm[0] && (in_imm[31:20] == {12{in_imm[31]}});
    assign u_ok = (in_imm[11:0] == 12'h000);

    always_comb begin
        enc_bits = '0;
        enc_err  = 1'b0;
        case (in_type)
            `RTYPE: enc_bits = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd};
            `ITYPE: begin
                enc_bits = {in_imm[11:0], in_rs1, in_funct3, in_rd};
                enc_err  = !i_ok;
            end
            `STYPE: begin
                enc_bits = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0]};
                enc_err  = !s_ok;
            end
            `BTYPE: begin
                enc_bits = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11]};
                enc_err  = !b_ok;
            end
            `UTYPE: begin
                enc_bits = {in_imm[31:12], in_rd};
                enc_err  = !u_ok;
            end
            `JTYPE: begin
                enc_bits = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd};
                enc_err  = !j_ok;
            end
            default: enc_err = 1'b1;
        endcase
`ifdef IMM_ENC_SPLIT_EN
        // the split path absorbs the range failure, so it is not reported as an error
        if (enc_split) enc_err = 1'b0;
`endif
    end

`ifdef IMM_ENC_SPLIT_EN
    // Rounding the upper part by imm[11] compensates for the sign-extended low 12 bits.
    assign enc_split  = (in_type == `ITYPE) && !i_ok;
    assign hi20       = in_imm[31:12] + {19'b0, in_imm[11]};
`endif

    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        bits_nxt  = out_bits;
        type_nxt  = out_type;
        last_nxt  = out_last;
        err_nxt   = out_err;
`ifdef IMM_ENC_SPLIT_EN
        beat2_nxt = beat2_bits;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    valid_nxt = 1'b1;
                    bits_nxt  = enc_bits;
                    type_nxt  = in_type;
                    last_nxt  = 1'b1;
                    err_nxt   = enc_err;
`ifdef IMM_ENC_SPLIT_EN
                    if (enc_split) begin
                        state_nxt = SPLIT;
                        bits_nxt  = {hi20, in_rd};
                        type_nxt  = `UTYPE;
                        last_nxt  = 1'b0;
                        beat2_nxt = {in_imm[11:0], in_rd, in_funct3, in_rd};
                    end
`endif
                end else if (consume) begin
                    valid_nxt = 1'b0;
                end
            end
`ifdef IMM_ENC_SPLIT_EN
            SPLIT: begin
                if (consume) begin
                    state_nxt = IDLE;
                    bits_nxt  = beat2_bits;
                    type_nxt  = `ITYPE;
                    last_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_bits  <= '0;
            out_type  <= `NOTYPE;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            err_count <= '0;
`ifdef IMM_ENC_SPLIT_EN
            beat2_bits <= '0;
`endif
        end else begin
            state     <= state_nxt;
            out_valid <= valid_nxt;
            out_bits  <= bits_nxt;
            out_type  <= type_nxt;
            out_last  <= last_nxt;
            out_err   <= err_nxt;
            if (accept && enc_err && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
`ifdef IMM_ENC_SPLIT_EN
            beat2_bits <= beat2_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed, table-driven bench for imm_field_encoder; adapts to IMM_ENC_SPLIT_EN.

`ifndef RTYPE
`define RTYPE  3'd0
`define ITYPE  3'd1
`define STYPE  3'd2
`define BTYPE  3'd3
`define UTYPE  3'd4
`define JTYPE  3'd5
`define NOTYPE 3'd7
`endif

module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_type;
    logic [31:0] in_imm;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        out_valid, out_ready;
    logic [24:0] out_bits;
    logic [2:0]  out_type;
    logic        out_last, out_err;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    imm_field_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_imm(in_imm),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_type(out_type),
        .out_last(out_last), .out_err(out_err),
        .err_count(err_count)
    );

    typedef struct {
        string       name;
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [24:0] bits;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7);
        in_valid  = 1'b1;
        in_type   = t;
        in_imm    = imm;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
    endtask

    task automatic chk_beat(input string name, input logic [2:0] t, input logic [24:0] bits,
                            input logic last, input logic err);
        chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, ".bits"},  {7'b0, out_bits},   {7'b0, bits});
        chk({name, ".type"},  {29'b0, out_type},  {29'b0, t});
        chk({name, ".last"},  {31'b0, out_last},  {31'b0, last});
        chk({name, ".err"},   {31'b0, out_err},   {31'b0, err});
    endtask

    initial begin
        vecs[0]  = '{"i_neg16",  `ITYPE,  32'hFFFFFFF0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 25'h1FE0201, 1'b0};
        vecs[1]  = '{"r_sub",    `RTYPE,  32'h00000000, 5'd4, 5'd2, 5'd3, 3'd5, 7'h20, 25'h08062A4, 1'b0};
        vecs[2]  = '{"s_neg4",   `STYPE,  32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 3'd2, 7'h00, 25'h1FC625C, 1'b0};
        vecs[3]  = '{"s_2048",   `STYPE,  32'h00000800, 5'd1, 5'd2, 5'd3, 3'd2, 7'h00, 25'h1006240, 1'b1};
        vecs[4]  = '{"b_odd",    `BTYPE,  32'h00000801, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 25'h0006201, 1'b1};
        vecs[5]  = '{"j_neg4k",  `JTYPE,  32'hFFFFF000, 5'd0, 5'd2, 5'd3, 3'd0, 7'h00, 25'h1001FE0, 1'b0};
        vecs[6]  = '{"b_neg8",   `BTYPE,  32'hFFFFFFF8, 5'd1, 5'd2, 5'd3, 3'd1, 7'h00, 25'h1FC6239, 1'b0};
        vecs[7]  = '{"u_ok",     `UTYPE,  32'hABCDE000, 5'd7, 5'd2, 5'd3, 3'd0, 7'h00, 25'h1579BC7, 1'b0};
        vecs[8]  = '{"u_low",    `UTYPE,  32'h00001001, 5'd7, 5'd2, 5'd3, 3'd0, 7'h00, 25'h0000027, 1'b1};
        vecs[9]  = '{"notype",   `NOTYPE, 32'h00000000, 5'd7, 5'd2, 5'd3, 3'd0, 7'h00, 25'h0000000, 1'b1};
        vecs[10] = '{"i_max",    `ITYPE,  32'h000007FF, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 25'h0FFE201, 1'b0};
        vecs[11] = '{"j_2pow20", `JTYPE,  32'h00100000, 5'd0, 5'd2, 5'd3, 3'd0, 7'h00, 25'h1000000, 1'b1};
        vecs[12] = '{"j_odd",    `JTYPE,  32'h00000003, 5'd0, 5'd2, 5'd3, 3'd0, 7'h00, 25'h0004000, 1'b1};
        vecs[13] = '{"i_min",    `ITYPE,  32'hFFFFF800, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 25'h1000201, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(`RTYPE, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.bits",  {7'b0, out_bits},   32'd0);
        chk("rst.type",  {29'b0, out_type},  {29'b0, `NOTYPE});
        chk("rst.last",  {31'b0, out_last},  32'd0);
        chk("rst.err",   {31'b0, out_err},   32'd0);
        chk("rst.errcnt", {16'b0, err_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back table vectors at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].typ, vecs[i].imm, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7);
            chk({vecs[i].name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
            if (i > 0) chk_beat(vecs[i-1].name, vecs[i-1].typ, vecs[i-1].bits, 1'b1, vecs[i-1].err);
            if (vecs[i].err) exp_errs++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_beat(vecs[13].name, vecs[13].typ, vecs[13].bits, 1'b1, vecs[13].err);
        chk("table.errcnt", {16'b0, err_count}, exp_errs);

        // backpressure: held beat stays stable, no acceptance, release is same-cycle
        @(negedge clk);
        chk("drain.valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        drive(vecs[10].typ, vecs[10].imm, vecs[10].rd, vecs[10].rs1, vecs[10].rs2, vecs[10].f3, vecs[10].f7);
        @(negedge clk);
        drive(vecs[1].typ, vecs[1].imm, vecs[1].rd, vecs[1].rs1, vecs[1].rs2, vecs[1].f3, vecs[1].f7);
        for (int c = 0; c < 3; c++) begin
            chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
            chk_beat("stall", vecs[10].typ, vecs[10].bits, 1'b1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("nobubble", vecs[1].typ, vecs[1].bits, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle.valid", {31'b0, out_valid}, 32'd0);

        // wide I-type immediate
        drive(`ITYPE, 32'h12345FFF, 5'd5, 5'd9, 5'd3, 3'd0, 7'd0);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef IMM_ENC_SPLIT_EN
        chk("split.in_ready", {31'b0, in_ready}, 32'd0);
        chk_beat("split.b1", `UTYPE, 25'h02468C5, 1'b0, 1'b0);
        @(negedge clk);
        chk_beat("split.b2", `ITYPE, 25'h1FFE505, 1'b1, 1'b0);
        @(negedge clk);
        chk("split.done", {31'b0, out_valid}, 32'd0);
        chk("split.errcnt", {16'b0, err_count}, exp_errs);

        // reset while beat 2 is pending
        out_ready = 1'b0;
        drive(`ITYPE, 32'h12345FFF, 5'd5, 5'd9, 5'd3, 3'd0, 7'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("splitrst.pre", {29'b0, out_type}, {29'b0, `UTYPE});
        #1 rst_n = 1'b0;
        #1;
        chk("splitrst.valid", {31'b0, out_valid}, 32'd0);
        chk("splitrst.bits",  {7'b0, out_bits},   32'd0);
        chk("splitrst.type",  {29'b0, out_type},  {29'b0, `NOTYPE});
        chk("splitrst.last",  {31'b0, out_last},  32'd0);
        chk("splitrst.errcnt", {16'b0, err_count}, 32'd0);
        #1 rst_n = 1'b1;
        exp_errs  = 0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("splitrst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("splitrst.nobeat2", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("splitrst.nobeat2b", {31'b0, out_valid}, 32'd0);
`else
        chk_beat("wideI", `ITYPE, 25'h1FFE905, 1'b1, 1'b1);
        exp_errs++;
        @(negedge clk);
        chk("wideI.errcnt", {16'b0, err_count}, exp_errs);
`endif

        // saturation of the error counter
        out_ready = 1'b1;
        drive(`NOTYPE, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        for (int n = 0; n < 65536; n++) begin
            @(negedge clk);
            if (exp_errs + n + 1 == 32'hFFFE) chk("sat.fffe", {16'b0, err_count}, 32'h0000FFFE);
        end
        chk("sat.ffff", {16'b0, err_count}, 32'h0000FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat.hold", {16'b0, err_count}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
